// File: rtl/spypath_array.sv
// Multi-channel launch/capture delay-chain monitor that counts chain mismatches per channel.
// Optional midpoint payload XOR per chain is compiled in with SPYPATH_HT_INSERT_EN.
module spypath_array #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned STAGES   = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_trials,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic [CHANNELS-1:0]       ht_ctrl,
  output logic                      busy,
  output logic                      done,
  output logic [CHANNELS*CNT_W-1:0] err_cnt,
  output logic                      err_any
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LAUNCH  = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] CHECK   = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]          state;
  logic [CNT_W-1:0]    trials_q;
  logic [CNT_W-1:0]    trial_cnt;
  logic [CNT_W-1:0]    trial_nxt;
  logic [CHANNELS-1:0] mask_q;
  logic [CHANNELS-1:0] launch_q;
  logic [CHANNELS-1:0] capture_q;
  logic [CHANNELS-1:0] chain_out;
  logic                accept;

  assign accept    = (state == IDLE) && start;
  assign trial_nxt = trial_cnt + CNT_W'(1);
  assign busy      = (state == LAUNCH) || (state == CAPTURE) || (state == CHECK);
  assign done      = (state == DONE);
  assign err_any   = |err_cnt;

`ifndef SPYPATH_HT_INSERT_EN
  logic unused_ht;
  assign unused_ht = ^ht_ctrl;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      trials_q  <= '0;
      trial_cnt <= '0;
      mask_q    <= '0;
      launch_q  <= '0;
      capture_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            trials_q  <= num_trials;
            mask_q    <= ch_mask;
            trial_cnt <= '0;
            state     <= (num_trials == '0) ? DONE : LAUNCH;
          end
        end
        LAUNCH: begin
          launch_q <= ~launch_q;
          state    <= CAPTURE;
        end
        CAPTURE: begin
          capture_q <= chain_out;
          state     <= CHECK;
        end
        CHECK: begin
          trial_cnt <= trial_nxt;
          state     <= (trial_nxt == trials_q) ? DONE : LAUNCH;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : ch
    logic [CNT_W-1:0] cnt_q;

    // Each stage lives in its own scope so every inverter is a distinct kept net.
    for (genvar s = 0; s < STAGES; s++) begin : stg
      logic n_in;
      (* keep = "true" *) logic n;
      if (s == 0) begin : first
        assign n_in = launch_q[g];
      end
`ifdef SPYPATH_HT_INSERT_EN
      else if (s == STAGES / 2) begin : payload
        (* keep = "true" *) logic x;
        assign x    = stg[s-1].n ^ ht_ctrl[g];
        assign n_in = x;
      end
`endif
      else begin : link
        assign n_in = stg[s-1].n;
      end
      assign n = ~n_in;
    end

    assign chain_out[g] = stg[STAGES-1].n;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q <= '0;
      end else if ((state == CHECK) && mask_q[g] && (capture_q[g] != launch_q[g]) &&
                   (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign err_cnt[g*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_spypath_array.sv
// Directed bench for spypath_array: default instance plus a CNT_W=4 instance with forced mismatches.
module tb_spypath_array;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_start = 1'b0;
  logic [15:0] a_n = '0;
  logic [3:0]  a_mask = '0, a_ht = '0;
  logic        a_busy, a_done, a_any;
  logic [63:0] a_err;

  logic        b_start = 1'b0;
  logic [3:0]  b_n = '0;
  logic [3:0]  b_mask = '0, b_ht = '0;
  logic        b_busy, b_done, b_any;
  logic [15:0] b_err;

  spypath_array dut (
    .clk(clk), .rst_n(rst_n), .start(a_start), .num_trials(a_n), .ch_mask(a_mask),
    .ht_ctrl(a_ht), .busy(a_busy), .done(a_done), .err_cnt(a_err), .err_any(a_any)
  );

  spypath_array #(.CHANNELS(4), .STAGES(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .num_trials(b_n), .ch_mask(b_mask),
    .ht_ctrl(b_ht), .busy(b_busy), .done(b_done), .err_cnt(b_err), .err_any(b_any)
  );

  typedef struct {
    int unsigned lat;
    logic [63:0] err;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input bit b);
    return b ? b_done : a_done;
  endfunction

  function automatic logic sel_busy(input bit b);
    return b ? b_busy : a_busy;
  endfunction

  function automatic logic sel_any(input bit b);
    return b ? b_any : a_any;
  endfunction

  function automatic logic [63:0] sel_err(input bit b);
    return b ? {48'h0, b_err} : a_err;
  endfunction

  // inv marks channels whose chain output is inverted relative to launch
  function automatic logic [63:0] model_err(input bit b, input int unsigned n,
                                            input logic [3:0] mask, input logic [3:0] inv);
    logic [63:0] r;
    int unsigned w, sat, v;
    r   = '0;
    w   = b ? 4 : 16;
    sat = (32'd1 << w) - 1;
    v   = (n > sat) ? sat : n;
    for (int i = 0; i < 4; i++)
      if (mask[i] && inv[i]) r = r | (64'(v) << (i * w));
    return r;
  endfunction

  // Called at a negedge; leaves the caller at the negedge of cycle 1 after acceptance.
  task automatic start_run(input bit b, input int unsigned n, input logic [3:0] mask,
                           input logic [3:0] inv);
    exp_t e;
    e.lat = (n == 0) ? 1 : 3 * n + 1;
    e.err = model_err(b, n, mask, inv);
    sb.push_back(e);
    if (b) begin
      b_n = 4'(n); b_mask = mask; b_start = 1'b1;
    end else begin
      a_n = 16'(n); a_mask = mask; a_start = 1'b1;
    end
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic finish_run(input bit b, input string tag, input bit poke);
    int unsigned cyc;
    int unsigned extra;
    exp_t e;
    cyc = 1;
    chk({tag, "_busy1"}, 64'(sel_busy(b)), 64'(sb[0].lat != 1));
    while (!sel_done(b) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (poke) begin
        a_start = (cyc == 2 || cyc == 5);
        a_n     = 16'd1;
        a_mask  = 4'h0;
      end
    end
    a_start = 1'b0;
    e = sb.pop_front();
    chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
    chk({tag, "_err"}, sel_err(b), e.err);
    chk({tag, "_any"}, 64'(sel_any(b)), 64'(e.err != 0));
    chk({tag, "_busy_done"}, 64'(sel_busy(b)), 64'd0);
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (sel_done(b)) extra++;
    end
    chk({tag, "_extra_done"}, 64'(extra), 64'd0);
    chk({tag, "_hold"}, sel_err(b), e.err);
  endtask

  logic [3:0] ht_inv;

  initial begin
`ifdef SPYPATH_HT_INSERT_EN
    ht_inv = 4'b0100;
`else
    ht_inv = 4'b0000;
`endif
    force dut4.chain_out = ~dut4.launch_q;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_done", 64'(a_done), 64'd0);
    chk("rst_err", a_err, 64'd0);
    chk("rst_any", 64'(a_any), 64'd0);
    chk("rst_err4", 64'(b_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_run(1'b0, 10, 4'hF, 4'h0);
    finish_run(1'b0, "n10", 1'b0);

    a_ht = 4'b0100;
    start_run(1'b0, 5, 4'hF, ht_inv);
    finish_run(1'b0, "ht_all", 1'b0);
    start_run(1'b0, 5, 4'b1011, ht_inv);
    finish_run(1'b0, "ht_masked", 1'b0);
    a_ht = 4'b0000;

    start_run(1'b0, 3, 4'hF, 4'h0);
    finish_run(1'b0, "restart_ignored", 1'b1);

    start_run(1'b0, 0, 4'hF, 4'h0);
    finish_run(1'b0, "n0", 1'b0);

    start_run(1'b1, 15, 4'b0001, 4'hF);
    finish_run(1'b1, "sat_run1", 1'b0);
    start_run(1'b1, 15, 4'b0001, 4'hF);
    finish_run(1'b1, "sat_run2", 1'b0);
    start_run(1'b1, 15, 4'b0011, 4'hF);
    finish_run(1'b1, "two_ch", 1'b0);
    start_run(1'b1, 0, 4'b0001, 4'hF);
    finish_run(1'b1, "n0_clear", 1'b0);

    start_run(1'b1, 10, 4'b0001, 4'hF);
    repeat (6) @(negedge clk);
    chk("mid_err", 64'(b_err), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(b_busy), 64'd0);
    chk("abort_done", 64'(b_done), 64'd0);
    chk("abort_err", 64'(b_err), 64'd0);
    chk("abort_any", 64'(b_any), 64'd0);
    chk("abort_trial", 64'(dut4.trial_cnt), 64'd0);
    chk("abort_launch", 64'(dut4.launch_q), 64'd0);
    chk("abort_capture", 64'(dut4.capture_q), 64'd0);
    sb.delete();
    @(negedge clk);
    chk("abort_nodone", 64'(b_done), 64'd0);
    rst_n = 1'b1;
    start_run(1'b1, 2, 4'b0001, 4'hF);
    finish_run(1'b1, "post_reset", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spypath_array.md
SPYPATH_ARRAY -- requirements
Module: spypath_array

Interface
REQ-001 The module SHALL have parameter CHANNELS, default 4, giving the number of independent delay chains.
REQ-002 The module SHALL have parameter STAGES, default 32, giving the inverter stages per chain; it SHALL be even and at least 2.
REQ-003 The module SHALL have parameter CNT_W, default 16, giving the width of the trial counter and each error counter.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, with launch and capture on rising edges.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: a one-cycle request to begin a measurement run.
REQ-007 The module SHALL have port num_trials, input, CNT_W bits: launch/capture trials per run, sampled when start is accepted.
REQ-008 The module SHALL have port ch_mask, input, CHANNELS bits: a 1 enables error counting for that channel, sampled when start is accepted.
REQ-009 The module SHALL have port ht_ctrl, input, CHANNELS bits: per-channel payload gate control, used only under REQ-029.
REQ-010 The module SHALL have port busy, output, 1 bit: high from start acceptance until done.
REQ-011 The module SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a run.
REQ-012 The module SHALL have port err_cnt, output, CHANNELS*CNT_W bits: per-channel mismatch counts, with channel i in bits [i*CNT_W +: CNT_W].
REQ-013 The module SHALL have port err_any, output, 1 bit: OR of all nonzero err_cnt fields.

Function
REQ-014 Each channel SHALL consist of a launch register, a STAGES-long chain of inverters, and a capture register sampling the chain output; every chain gate SHALL be preserved through synthesis.
REQ-015 The FSM SHALL have exactly the states IDLE, LAUNCH, CAPTURE, CHECK and DONE.
REQ-016 In IDLE, start=1 SHALL latch num_trials and ch_mask, clear all err_cnt and the trial counter, and move to LAUNCH, or to DONE if num_trials=0.
REQ-017 At the end of the LAUNCH cycle, all launch registers SHALL toggle simultaneously.
REQ-018 At the end of the CAPTURE cycle, each capture register SHALL sample its chain output, giving one full clock period of propagation.
REQ-019 In CHECK, a channel SHALL be a mismatch when its capture register differs from its launch register (even STAGES, so the chain is non-inverting).
REQ-020 In CHECK, the err_cnt of each masked-in mismatching channel SHALL increment by 1, saturating at all-ones without wrap.
REQ-021 In CHECK, the trial counter SHALL increment, and the FSM SHALL go to DONE if the trial count now equals the latched num_trials, else to LAUNCH.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle before the FSM returns to IDLE.
REQ-023 Latency SHALL be 3*N+1 cycles from start acceptance to the done cycle for N>0, and 1 cycle for N=0.
REQ-024 busy SHALL be 1 in LAUNCH, CAPTURE and CHECK, and 0 in IDLE and DONE; start SHALL be ignored while not in IDLE.
REQ-025 err_cnt SHALL hold its value after done until the next accepted start.
REQ-026 ch_mask and num_trials changes during a run SHALL have no effect on that run.

Reset
REQ-027 rst_n=0 SHALL force, asynchronously: FSM to IDLE; busy=0; done=0; all err_cnt=0; err_any=0; all launch, capture and trial counter registers to 0.
REQ-028 Reset asserted mid-run SHALL abort the run with no done pulse; after release, the block SHALL accept a new start on the first cycle.

Configuration
REQ-029 With macro SPYPATH_HT_INSERT_EN defined, each channel SHALL contain an XOR gate at chain midpoint (after stage STAGES/2) whose second input is ht_ctrl[i]; ht_ctrl[i]=1 SHALL invert that channel's chain output, and ht_ctrl[i]=0 SHALL add only the XOR gate delay.
REQ-030 With SPYPATH_HT_INSERT_EN undefined, no XOR gate SHALL exist and ht_ctrl SHALL be ignored.

Verification
REQ-031 Slow clock, num_trials=10, ch_mask=4'hF, ht_ctrl=0 -> done at cycle 31 after start, all err_cnt=0, err_any=0.
REQ-032 With SPYPATH_HT_INSERT_EN defined, ht_ctrl=4'b0100, num_trials=5, ch_mask=4'hF -> err_cnt[2]=5, other channels 0, err_any=1.
REQ-033 As REQ-032 with ch_mask=4'b1011 -> all err_cnt=0.
REQ-034 CNT_W=4, forced mismatch on channel 0, num_trials=15 run twice (err_cnt clears at the second start) -> err_cnt[0]=15 after each run; after a run with num_trials=0, done follows start by 1 cycle and err_cnt=0.
REQ-035 rst_n pulsed low during the 3rd trial -> busy=0 and all counters 0 immediately, no done pulse, and a new start is accepted on the next cycle.
REQ-036 start reasserted while busy -> ignored, and the done pulse occurs exactly once at the original latency.
